// File: rtl/button_event_arbiter_if.sv
// Event handshake bundle between button_event_arbiter (master) and its consumer (slave).
interface button_event_arbiter_if;
  logic       evt_valid;
  logic       evt_ready;
  logic [2:0] evt_id;
  logic [1:0] evt_kind;

  modport master (output evt_valid, output evt_id, output evt_kind, input evt_ready);
  modport slave  (input evt_valid, input evt_id, input evt_kind, output evt_ready);
endinterface

// File: rtl/button_event_arbiter.sv
// Round-robin arbiter turning per-button press/release pulses into one valid/ready event stream.
// Define BUTTON_AUTO_REPEAT_EN to add per-button hold counters that raise repeat events.
module button_event_arbiter #(
  parameter int unsigned N_BTN        = 4,
  parameter logic [23:0] REPEAT_DELAY = 24'd5000000,
  parameter logic [23:0] REPEAT_RATE  = 24'd1000000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_BTN-1:0]       btn_down,
  input  logic [N_BTN-1:0]       btn_up,
  input  logic [N_BTN-1:0]       btn_state,
  button_event_arbiter_if.master evt,
  output logic [7:0]             drop_cnt
);

  localparam logic [1:0] KIND_PRESS   = 2'b00;
  localparam logic [1:0] KIND_RELEASE = 2'b01;
  localparam logic [1:0] KIND_REPEAT  = 2'b10;
  localparam logic [2:0] LAST_RST     = 3'(N_BTN - 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_OFFER = 1'b1} state_t;

  state_t           r_state, w_state_n;
  logic             r_evt_valid, w_evt_valid_n;
  logic [2:0]       r_evt_id, w_evt_id_n;
  logic [1:0]       r_evt_kind, w_evt_kind_n;
  logic [2:0]       r_last, w_last_n;
  logic [7:0]       r_drop_cnt, w_drop_cnt_n;
  logic [N_BTN-1:0] r_p, r_r, w_p_n, w_r_n;
  logic [N_BTN-1:0] w_t_pend, w_pend;
  logic [N_BTN-1:0] w_gnt_p, w_gnt_r, w_off_r;
  logic [N_BTN-1:0] w_hi_req, w_lo_req;
  logic             w_hs;
  logic             w_hi_found, w_lo_found;
  logic [2:0]       w_hi_id, w_lo_id;
  logic [1:0]       w_hi_kind, w_lo_kind;
  logic [4:0]       w_drop_inc;
  logic [8:0]       w_drop_sum;

  function automatic logic [1:0] pick_kind(input logic p, input logic r);
    pick_kind = p ? KIND_PRESS : (r ? KIND_RELEASE : KIND_REPEAT);
  endfunction

  assign w_hs   = r_evt_valid & evt.evt_ready;
  assign w_pend = r_p | r_r | w_t_pend;

  // Decode which pending bit is currently offered / being granted.
  always_comb begin
    w_gnt_p = '0;
    w_gnt_r = '0;
    w_off_r = '0;
    for (int i = 0; i < N_BTN; i++) begin
      w_off_r[i] = r_evt_valid & (r_evt_id == 3'(i)) & (r_evt_kind == KIND_RELEASE);
      w_gnt_r[i] = w_hs & w_off_r[i];
      w_gnt_p[i] = w_hs & (r_evt_id == 3'(i)) & (r_evt_kind == KIND_PRESS);
    end
  end

  // Round-robin pick: lowest pending index above r_last wins, else lowest index at/below it.
  always_comb begin
    w_hi_req   = '0;
    w_lo_req   = '0;
    w_hi_found = 1'b0;
    w_lo_found = 1'b0;
    w_hi_id    = 3'd0;
    w_lo_id    = 3'd0;
    w_hi_kind  = KIND_PRESS;
    w_lo_kind  = KIND_PRESS;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      w_hi_req[i] = w_pend[i] & (3'(i) > r_last);
      w_lo_req[i] = w_pend[i] & ~(3'(i) > r_last);
      w_hi_found  = w_hi_found | w_hi_req[i];
      w_lo_found  = w_lo_found | w_lo_req[i];
      w_hi_id     = w_hi_req[i] ? 3'(i) : w_hi_id;
      w_lo_id     = w_lo_req[i] ? 3'(i) : w_lo_id;
      w_hi_kind   = w_hi_req[i] ? pick_kind(r_p[i], r_r[i]) : w_hi_kind;
      w_lo_kind   = w_lo_req[i] ? pick_kind(r_p[i], r_r[i]) : w_lo_kind;
    end
  end

  // FSM next state and next values of the registered event outputs.
  always_comb begin
    w_state_n     = r_state;
    w_evt_valid_n = r_evt_valid;
    w_evt_id_n    = r_evt_id;
    w_evt_kind_n  = r_evt_kind;
    w_last_n      = r_last;
    case (r_state)
      ST_IDLE: begin
        if (w_hi_found || w_lo_found) begin
          w_state_n     = ST_OFFER;
          w_evt_valid_n = 1'b1;
          w_evt_id_n    = w_hi_found ? w_hi_id : w_lo_id;
          w_evt_kind_n  = w_hi_found ? w_hi_kind : w_lo_kind;
        end else begin
          w_evt_valid_n = 1'b0;
        end
      end
      ST_OFFER: begin
        if (evt.evt_ready) begin
          w_state_n     = ST_IDLE;
          w_evt_valid_n = 1'b0;
          w_last_n      = r_evt_id;
        end else begin
          w_evt_valid_n = 1'b1;
        end
      end
      default: begin
        w_state_n     = ST_IDLE;
        w_evt_valid_n = 1'b0;
      end
    endcase
  end

  // Pending-bit update; a press cancels a release only while that release is not on offer.
  always_comb begin
    w_p_n      = r_p;
    w_r_n      = r_r;
    w_drop_inc = 5'd0;
    for (int i = 0; i < N_BTN; i++) begin
      w_p_n[i]   = btn_down[i] | (r_p[i] & ~w_gnt_p[i]);
      w_r_n[i]   = btn_up[i] | (r_r[i] & ~w_gnt_r[i] & ~(btn_down[i] & ~w_off_r[i]));
      w_drop_inc = w_drop_inc + {4'd0, btn_down[i] & r_p[i] & ~w_gnt_p[i]}
                              + {4'd0, btn_up[i] & r_r[i] & ~w_gnt_r[i]};
    end
    w_drop_sum   = {1'b0, r_drop_cnt} + {4'd0, w_drop_inc};
    w_drop_cnt_n = (w_drop_sum > 9'd255) ? 8'd255 : w_drop_sum[7:0];
  end

  // State, event output and pending registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_evt_valid <= 1'b0;
      r_evt_id    <= 3'd0;
      r_evt_kind  <= KIND_PRESS;
      r_last      <= LAST_RST;
      r_drop_cnt  <= 8'd0;
      r_p         <= '0;
      r_r         <= '0;
    end else begin
      r_state     <= w_state_n;
      r_evt_valid <= w_evt_valid_n;
      r_evt_id    <= w_evt_id_n;
      r_evt_kind  <= w_evt_kind_n;
      r_last      <= w_last_n;
      r_drop_cnt  <= w_drop_cnt_n;
      r_p         <= w_p_n;
      r_r         <= w_r_n;
    end
  end

`ifdef BUTTON_AUTO_REPEAT_EN
  logic [23:0]      r_hold [N_BTN];
  logic [N_BTN-1:0] r_t, w_t_set, w_gnt_t;

  // Repeat fires when the hold count reaches REPEAT_DELAY; the counter then rewinds by REPEAT_RATE.
  always_comb begin
    w_t_set = '0;
    w_gnt_t = '0;
    for (int i = 0; i < N_BTN; i++) begin
      w_t_set[i] = btn_state[i] & ~btn_down[i] & ((r_hold[i] + 24'd1) == REPEAT_DELAY);
      w_gnt_t[i] = w_hs & (r_evt_id == 3'(i)) & (r_evt_kind == KIND_REPEAT);
    end
  end

  // Hold counters and coalescing repeat-pending bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_t <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        r_hold[i] <= 24'd0;
      end
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        r_t[i] <= w_t_set[i] | (r_t[i] & ~w_gnt_t[i]);
        if (btn_down[i] || !btn_state[i]) begin
          r_hold[i] <= 24'd0;
        end else if (w_t_set[i]) begin
          r_hold[i] <= REPEAT_DELAY - REPEAT_RATE;
        end else begin
          r_hold[i] <= r_hold[i] + 24'd1;
        end
      end
    end
  end

  assign w_t_pend = r_t;
`else
  logic w_unused_state;
  assign w_unused_state = ^btn_state;
  assign w_t_pend       = '0;
`endif

  assign evt.evt_valid = r_evt_valid;
  assign evt.evt_id    = r_evt_id;
  assign evt.evt_kind  = r_evt_kind;
  assign drop_cnt      = r_drop_cnt;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed self-checking bench for button_event_arbiter; repeat expectations follow BUTTON_AUTO_REPEAT_EN.
module tb_button_event_arbiter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] btn_down;
  logic [3:0] btn_up;
  logic [3:0] btn_state;
  logic [7:0] drop_cnt;
  int         n_checks = 0;
  int         n_pass   = 0;

  button_event_arbiter_if u_if ();

  button_event_arbiter #(
    .N_BTN       (4),
    .REPEAT_DELAY(24'd10),
    .REPEAT_RATE (24'd4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_down (btn_down),
    .btn_up   (btn_up),
    .btn_state(btn_state),
    .evt      (u_if.master),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n          = 1'b0;
    btn_down       = 4'b0000;
    btn_up         = 4'b0000;
    btn_state      = 4'b0000;
    u_if.evt_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input int max_cycles, output bit ok);
    ok = (u_if.evt_valid === 1'b1);
    for (int c = 0; c < max_cycles && !ok; c++) begin
      tick();
      ok = (u_if.evt_valid === 1'b1);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if (u_if.evt_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", u_if.evt_valid);
    else n_pass++;
    n_checks++;
    if (u_if.evt_id !== 3'd0) $display("FAIL reset_id: got %0d want 0", u_if.evt_id);
    else n_pass++;
    n_checks++;
    if (u_if.evt_kind !== 2'b00) $display("FAIL reset_kind: got %b want 00", u_if.evt_kind);
    else n_pass++;
    n_checks++;
    if (drop_cnt !== 8'd0) $display("FAIL reset_drop: got %0d want 0", drop_cnt);
    else n_pass++;
  endtask

  task automatic test_single_press();
    apply_reset();
    u_if.evt_ready = 1'b1;
    btn_down = 4'b0100;
    tick();
    btn_down = 4'b0000;
    n_checks++;
    if (u_if.evt_valid !== 1'b0) $display("FAIL single_early: got valid %b want 0", u_if.evt_valid);
    else n_pass++;
    tick();
    n_checks++;
    if ({u_if.evt_valid, u_if.evt_id, u_if.evt_kind} !== {1'b1, 3'd2, 2'b00})
      $display("FAIL single_offer: got v=%b id=%0d k=%b want v=1 id=2 k=00",
               u_if.evt_valid, u_if.evt_id, u_if.evt_kind);
    else n_pass++;
    tick();
    n_checks++;
    if (u_if.evt_valid !== 1'b0) $display("FAIL single_idle_gap: got valid %b want 0", u_if.evt_valid);
    else n_pass++;
    tick();
    n_checks++;
    if (u_if.evt_valid !== 1'b0) $display("FAIL single_no_extra: got valid %b want 0", u_if.evt_valid);
    else n_pass++;
  endtask

  task automatic test_all_press();
    bit ok;
    apply_reset();
    u_if.evt_ready = 1'b1;
    btn_down = 4'b1111;
    tick();
    btn_down = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      wait_valid(8, ok);
      n_checks++;
      if (!ok) $display("FAIL all_timeout: event %0d got none want valid", k);
      else n_pass++;
      n_checks++;
      if ({u_if.evt_id, u_if.evt_kind} !== {3'(k), 2'b00})
        $display("FAIL all_order: got id=%0d k=%b want id=%0d k=00", u_if.evt_id, u_if.evt_kind, k);
      else n_pass++;
      tick();
      n_checks++;
      if (u_if.evt_valid !== 1'b0) $display("FAIL all_idle_gap: got valid %b want 0", u_if.evt_valid);
      else n_pass++;
    end
    n_checks++;
    if (drop_cnt !== 8'd0) $display("FAIL all_drop: got %0d want 0", drop_cnt);
    else n_pass++;
  endtask

  task automatic test_drop();
    apply_reset();
    u_if.evt_ready = 1'b0;
    btn_down = 4'b0010;
    tick();
    tick();
    tick();
    btn_down = 4'b0000;
    n_checks++;
    if (drop_cnt !== 8'd2) $display("FAIL drop_count: got %0d want 2", drop_cnt);
    else n_pass++;
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if ({u_if.evt_valid, u_if.evt_id, u_if.evt_kind} !== {1'b1, 3'd1, 2'b00})
        $display("FAIL drop_stable: cycle %0d got v=%b id=%0d k=%b want v=1 id=1 k=00",
                 c, u_if.evt_valid, u_if.evt_id, u_if.evt_kind);
      else n_pass++;
      tick();
    end
    u_if.evt_ready = 1'b1;
    tick();
    n_checks++;
    if (u_if.evt_valid !== 1'b0) $display("FAIL drop_accept: got valid %b want 0", u_if.evt_valid);
    else n_pass++;
    tick();
    tick();
    n_checks++;
    if (u_if.evt_valid !== 1'b0) $display("FAIL drop_single_event: got valid %b want 0", u_if.evt_valid);
    else n_pass++;
  endtask

  task automatic test_same_edge();
    apply_reset();
    u_if.evt_ready = 1'b1;
    btn_down = 4'b1000;
    tick();
    btn_down = 4'b0000;
    tick();
    n_checks++;
    if ({u_if.evt_valid, u_if.evt_id} !== {1'b1, 3'd3})
      $display("FAIL same_first: got v=%b id=%0d want v=1 id=3", u_if.evt_valid, u_if.evt_id);
    else n_pass++;
    btn_down = 4'b1000;
    tick();
    btn_down = 4'b0000;
    n_checks++;
    if (u_if.evt_valid !== 1'b0) $display("FAIL same_gap: got valid %b want 0", u_if.evt_valid);
    else n_pass++;
    tick();
    n_checks++;
    if ({u_if.evt_valid, u_if.evt_id, u_if.evt_kind} !== {1'b1, 3'd3, 2'b00})
      $display("FAIL same_second: got v=%b id=%0d k=%b want v=1 id=3 k=00",
               u_if.evt_valid, u_if.evt_id, u_if.evt_kind);
    else n_pass++;
    tick();
    n_checks++;
    if (drop_cnt !== 8'd0) $display("FAIL same_drop: got %0d want 0", drop_cnt);
    else n_pass++;
  endtask

  task automatic test_release_cancel();
    apply_reset();
    u_if.evt_ready = 1'b0;
    btn_up = 4'b0101;
    tick();
    btn_up = 4'b0000;
    tick();
    n_checks++;
    if ({u_if.evt_valid, u_if.evt_id, u_if.evt_kind} !== {1'b1, 3'd0, 2'b01})
      $display("FAIL cancel_rel_offer: got v=%b id=%0d k=%b want v=1 id=0 k=01",
               u_if.evt_valid, u_if.evt_id, u_if.evt_kind);
    else n_pass++;
    btn_down = 4'b0101;
    tick();
    btn_down = 4'b0000;
    u_if.evt_ready = 1'b1;
    n_checks++;
    if ({u_if.evt_valid, u_if.evt_id, u_if.evt_kind} !== {1'b1, 3'd0, 2'b01})
      $display("FAIL cancel_rel_kept: got v=%b id=%0d k=%b want v=1 id=0 k=01",
               u_if.evt_valid, u_if.evt_id, u_if.evt_kind);
    else n_pass++;
    tick();
    tick();
    n_checks++;
    if ({u_if.evt_valid, u_if.evt_id, u_if.evt_kind} !== {1'b1, 3'd2, 2'b00})
      $display("FAIL cancel_press2: got v=%b id=%0d k=%b want v=1 id=2 k=00",
               u_if.evt_valid, u_if.evt_id, u_if.evt_kind);
    else n_pass++;
    tick();
    tick();
    n_checks++;
    if ({u_if.evt_valid, u_if.evt_id, u_if.evt_kind} !== {1'b1, 3'd0, 2'b00})
      $display("FAIL cancel_press0: got v=%b id=%0d k=%b want v=1 id=0 k=00",
               u_if.evt_valid, u_if.evt_id, u_if.evt_kind);
    else n_pass++;
    tick();
    tick();
    tick();
    n_checks++;
    if (u_if.evt_valid !== 1'b0) $display("FAIL cancel_no_stale: got valid %b want 0", u_if.evt_valid);
    else n_pass++;
    n_checks++;
    if (drop_cnt !== 8'd0) $display("FAIL cancel_drop: got %0d want 0", drop_cnt);
    else n_pass++;
  endtask

  task automatic test_repeat();
    int n_evt;
    int exp_n;
    int got_cyc [8];
    int got_id [8];
    int got_kind [8];
    int exp_cyc [8];
    int exp_kind [8];
    apply_reset();
    u_if.evt_ready = 1'b1;
    n_evt = 0;
    got_cyc  = '{-1, -1, -1, -1, -1, -1, -1, -1};
    got_id   = '{-1, -1, -1, -1, -1, -1, -1, -1};
    got_kind = '{-1, -1, -1, -1, -1, -1, -1, -1};
`ifdef BUTTON_AUTO_REPEAT_EN
    exp_n    = 6;
    exp_cyc  = '{1, 11, 15, 19, 23, 25, 0, 0};
    exp_kind = '{0, 2, 2, 2, 2, 1, 0, 0};
`else
    exp_n    = 2;
    exp_cyc  = '{1, 24, 0, 0, 0, 0, 0, 0};
    exp_kind = '{0, 1, 0, 0, 0, 0, 0, 0};
`endif
    for (int c = 0; c < 40; c++) begin
      btn_down  = (c == 0)  ? 4'b0001 : 4'b0000;
      btn_up    = (c == 23) ? 4'b0001 : 4'b0000;
      btn_state = (c <= 22) ? 4'b0001 : 4'b0000;
      tick();
      if (u_if.evt_valid === 1'b1) begin
        if (n_evt < 8) begin
          got_cyc[n_evt]  = c;
          got_id[n_evt]   = int'(u_if.evt_id);
          got_kind[n_evt] = int'(u_if.evt_kind);
        end
        n_evt++;
      end
    end
    btn_down  = 4'b0000;
    btn_up    = 4'b0000;
    btn_state = 4'b0000;
    n_checks++;
    if (n_evt != exp_n) $display("FAIL repeat_count: got %0d events want %0d", n_evt, exp_n);
    else n_pass++;
    for (int k = 0; k < exp_n; k++) begin
      n_checks++;
      if (got_cyc[k] != exp_cyc[k] || got_id[k] != 0 || got_kind[k] != exp_kind[k])
        $display("FAIL repeat_event%0d: got cyc=%0d id=%0d k=%0d want cyc=%0d id=0 k=%0d",
                 k, got_cyc[k], got_id[k], got_kind[k], exp_cyc[k], exp_kind[k]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_in_offer();
    apply_reset();
    u_if.evt_ready = 1'b0;
    btn_down = 4'b0010;
    btn_up   = 4'b0100;
    tick();
    btn_down = 4'b0000;
    btn_up   = 4'b0000;
    tick();
    btn_down = 4'b0010;
    tick();
    btn_down = 4'b0000;
    n_checks++;
    if ({u_if.evt_valid, drop_cnt} !== {1'b1, 8'd1})
      $display("FAIL rst_setup: got v=%b drop=%0d want v=1 drop=1", u_if.evt_valid, drop_cnt);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (u_if.evt_valid !== 1'b0) $display("FAIL rst_async_valid: got %b want 0", u_if.evt_valid);
    else n_pass++;
    n_checks++;
    if ({drop_cnt, u_if.evt_id, u_if.evt_kind} !== {8'd0, 3'd0, 2'b00})
      $display("FAIL rst_async_regs: got drop=%0d id=%0d k=%b want 0 0 00",
               drop_cnt, u_if.evt_id, u_if.evt_kind);
    else n_pass++;
    tick();
    rst_n = 1'b1;
    u_if.evt_ready = 1'b1;
    tick();
    tick();
    tick();
    n_checks++;
    if (u_if.evt_valid !== 1'b0) $display("FAIL rst_pending_cleared: got valid %b want 0", u_if.evt_valid);
    else n_pass++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    rst_n          = 1'b0;
    btn_down       = 4'b0000;
    btn_up         = 4'b0000;
    btn_state      = 4'b0000;
    u_if.evt_ready = 1'b0;
    test_reset();
    test_single_press();
    test_all_press();
    test_drop();
    test_same_edge();
    test_release_cancel();
    test_repeat();
    test_reset_in_offer();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
